// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   - state_e       : controller states (IDLE / SHIFT / DONE)
//   - DEFAULT_WIDTH : default operand width
//   - calc_cnt_w()  : width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 5;

  // The counter must be able to hold the value WIDTH, hence WIDTH+1 codes.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// ---------------------------------------------------------------------------
// serial_sub_cell
// Purely combinational 1-bit full adder. The parent feeds it one operand bit
// pair per clock together with the registered carry.
// Ports:
//   x_i, y_i : operand bits
//   cin_i    : carry in
//   s_o      : sum bit
//   cout_o   : carry out (majority of the three inputs)
// ---------------------------------------------------------------------------
module serial_sub_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = x_i ^ y_i ^ cin_i;
  assign cout_o = (x_i & y_i) | (x_i & cin_i) | (y_i & cin_i);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit unsigned subtractor, D = A - B mod 2^WIDTH, computed
// LSB first as A + ~B + 1 with one full-adder cell and a registered carry.
// A start/done handshake talks to the upstream controller; one result per
// WIDTH+1 clocks, back-to-back starts accepted in the DONE cycle.
//
// Ports:
//   clk_i    : rising-edge clock
//   rst_i    : synchronous active-high reset
//   start_i  : request, sampled only in IDLE or DONE
//   a_i      : minuend, captured when start is accepted
//   b_i      : subtrahend, captured when start is accepted
//   busy_o   : high while bits are being shifted
//   done_o   : one-cycle pulse, d_o/bout_o valid from this cycle on
//   d_o      : difference, held until the next result or reset
//   bout_o   : borrow out, 1 iff A < B (unsigned)
//   ovf_o    : signed overflow of A - B (only with the macro below)
//
// Build option:
//   SERIAL_SUB_SIGNED_OVF_EN - when defined, adds ovf_o (carry into MSB XOR
//   carry out of MSB), updated together with d_o.
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CNT_W = calc_cnt_w(WIDTH);

  // Controller
  state_e           state_q;
  state_e           state_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             load_en;
  logic             shift_en;
  logic             last_bit;

  // Datapath
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  // Only WIDTH-1 partial bits are ever stored: the final sum bit goes
  // straight into the result register together with the stored bits.
  logic [WIDTH-2:0] acc_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sum;
  logic             cout;
  logic [WIDTH-1:0] acc_full;

  // Result registers
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf_q;
`endif

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  serial_sub_cell u_cell (
    .x_i    (sa_q[0]),
    .y_i    (sb_q[0]),
    .cin_i  (carry_q),
    .s_o    (sum),
    .cout_o (cout)
  );

  // Current sum bit on top of the bits collected so far.
  assign acc_full = {sum, acc_q};

  // State register plus registered busy/done flags decoded from next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = SHIFT;
        else         state_d = IDLE;
      end
      SHIFT: begin
        if (last_bit) state_d = DONE;
        else          state_d = SHIFT;
      end
      DONE: begin
        if (start_i) state_d = SHIFT;
        else         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller outputs: datapath enables and next values of busy/done.
  always_comb begin
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE:    load_en  = start_i;
      DONE:    load_en  = start_i;
      SHIFT:   shift_en = 1'b1;
      default: begin
        load_en  = 1'b0;
        shift_en = 1'b0;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // Operand shift registers, carry and bit counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      acc_q   <= {(WIDTH-1){1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else if (load_en) begin
      sa_q    <= a_i;
      sb_q    <= ~b_i;
      acc_q   <= {(WIDTH-1){1'b0}};
      carry_q <= 1'b1;               // the "+1" of the two's complement
      cnt_q   <= {CNT_W{1'b0}};
    end else if (shift_en) begin
      sa_q    <= {1'b0, sa_q[WIDTH-1:1]};
      sb_q    <= {1'b0, sb_q[WIDTH-1:1]};
      acc_q   <= acc_full[WIDTH-1:1];
      carry_q <= cout;
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Result capture on the last shift so d/bout are valid during the done
  // pulse; they then hold until the next result or reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q    <= {WIDTH{1'b0}};
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (shift_en && last_bit) begin
      d_q    <= acc_full;
      bout_q <= ~cout;               // no carry out means a borrow occurred
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      // carry_q is the carry into the MSB cell on this last bit.
      ovf_q  <= carry_q ^ cout;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign d_o    = d_q;
  assign bout_o = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit unsigned subtractor computing D = A - B, LSB first, one bit per clock, using a single full-adder cell with a registered carry (two's-complement add of ~B + 1).
- The sequential counterpart to the team's combinational ripple adders: trades WIDTH cells for one cell plus a small FSM.
- Used where area matters more than latency. Start/done handshake to the upstream controller.

Parameters:
- WIDTH, 5, operand/result width in bits (legal range 2..16).
- CNT_W, $clog2(WIDTH+1), bit counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when result is valid
- d  output  WIDTH  difference, A - B mod 2^WIDTH
- bout  output  1  borrow out; 1 iff A < B (unsigned)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; busy=0, done=0, d=0, bout=0; internal shift registers, carry and counter cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1: load sa<=a, sb<=~b, carry<=1, cnt<=0, acc<=0; go to SHIFT.
  - Else stay in IDLE.
- SHIFT (busy=1): each cycle:
  - sum = sa[0]^sb[0]^carry; carry <= majority(sa[0], sb[0], carry).
  - acc <= {sum, acc[WIDTH-1:1]}; sa and sb shift right by one; cnt <= cnt+1.
  - When cnt==WIDTH-1 (last bit): next state is DONE.
  - start is ignored in SHIFT; a and b may change freely.
- DONE (one cycle):
  - done=1; d<=acc; bout<=~carry_final.
  - If start=1 in this cycle, the new operands load and the next state is SHIFT (back-to-back). Otherwise go to IDLE.
- Latency: start accepted at edge N; done is high in the cycle after edge N+WIDTH. With WIDTH=5, done is visible 6 cycles after start is sampled.
- Throughput: one result per WIDTH+1 cycles.
- d and bout hold their value from the DONE cycle until the next DONE or reset. They are not updated during SHIFT.
- Arithmetic: modulo 2^WIDTH. bout = NOT carry-out of A + ~B + 1.
- Edge cases:
  - A==B gives d=0, bout=0.
  - B=0 gives d=A, bout=0.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN
- Defined: adds output port ovf (1 bit, reset 0), updated in DONE together with d.
  - ovf = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow of A - B.
  - The carry into the MSB is captured in SHIFT when cnt==WIDTH-1.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default WIDTH constant;
  - a function computing CNT_W.
- One sub-module: serial_sub_cell, a purely combinational 1-bit full adder (x, y, cin -> s, cout) instantiated once. The carry register stays in the parent.

Test Plan:
- Basic: a=5, b=3, start pulse -> done after 6 cycles; d=2, bout=0; busy high for exactly 5 cycles.
- Borrow: a=3, b=5 -> d=5'b11110 (30), bout=1; a=0, b=1 -> d=31, bout=1; a=31, b=31 -> d=0, bout=0.
- Back-to-back: start held high with a=10, b=4, then a=4, b=10 presented in the DONE cycle -> two done pulses 6 cycles apart; d=6, bout=0, then d=26, bout=1.
- Ignored start and operand change: start=1 and a/b changed mid-SHIFT -> result still matches the operands captured at acceptance; no extra done pulse.
- Reset mid-op: rst asserted in the 3rd SHIFT cycle -> next cycle all outputs 0, state IDLE, no done pulse. A new start then completes normally.
- With SERIAL_SUB_SIGNED_OVF_EN: a=15, b=16 -> d=31, bout=1, ovf=1; a=5, b=3 -> ovf=0; exhaustive 32x32 sweep against a reference model.
